// File: rtl/cmp_offset_calibrator_if.sv
// Calibrator <-> analog front-end bundle: start request, comparator outputs,
// reference DAC code, trim words and measurement/status reporting.
interface cmp_offset_calibrator_if #(
    parameter int N_CMP     = 31,
    parameter int DAC_BITS  = 16,
    parameter int TRIM_BITS = 8,
    parameter int IDX_W     = (N_CMP > 1) ? $clog2(N_CMP) : 1
);
    logic                       start;
    logic [N_CMP-1:0]           q;
    logic [DAC_BITS-1:0]        dac_ctl;
    logic [N_CMP*TRIM_BITS-1:0] cal;
    logic                       busy;
    logic                       done;
    logic                       meas_valid;
    logic [IDX_W-1:0]           meas_idx;
    logic [DAC_BITS-1:0]        meas_code;
    logic [N_CMP-1:0]           trim_sat;

    modport master (
        input  start, q,
        output dac_ctl, cal, busy, done, meas_valid, meas_idx, meas_code, trim_sat
    );
    modport slave (
        output start, q,
        input  dac_ctl, cal, busy, done, meas_valid, meas_idx, meas_code, trim_sat
    );
endinterface

// File: rtl/cmp_offset_calibrator.sv
// Flash-ADC comparator offset calibrator: per-comparator SAR trip-code measurement followed by a
// sign-magnitude trim search. Define CAL_VERIFY_EN to append a verify SAR pass with trims applied.
module cmp_offset_calibrator #(
    parameter int N_CMP     = 31,
    parameter int DAC_BITS  = 16,
    parameter int TRIM_BITS = 8,
    parameter int SETTLE    = 1,
    parameter int TGT_BASE  = 13033,
    parameter int TGT_STEP  = 1117,
    parameter int INV_FROM  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    cmp_offset_calibrator_if.master bus
);
    localparam int IDX_W = (N_CMP > 1) ? $clog2(N_CMP) : 1;
    localparam int BIT_W = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int MAG_W = TRIM_BITS - 1;
    localparam logic [IDX_W-1:0] LAST      = IDX_W'(N_CMP - 1);
    localparam logic [MAG_W-1:0] MAG_MAX   = '1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE, S_SAR_LOAD, S_SAR_SLOT, S_SAR_STORE, S_TRIM_ZERO, S_TRIM_STEP, S_DONE
    } state_t;

    state_t                          state_q;
    logic [IDX_W-1:0]                idx_q;
    logic [BIT_W-1:0]                bit_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [DAC_BITS-1:0]             dac_q, code_q;
    logic [N_CMP-1:0][TRIM_BITS-1:0] trim_q;
    logic [N_CMP-1:0]                sat_q;
    logic [MAG_W-1:0]                mag_q;
    logic                            sign_q, busy_q, done_q, mv_q;
`ifdef CAL_VERIFY_EN
    logic                            verify_q;
`endif

    logic                q_sel, slot_end;
    logic [DAC_BITS-1:0] bit_mask, sar_d;
    logic [IDX_W-1:0]    idx_inc;

    function automatic logic [DAC_BITS-1:0] tgt_of(input logic [IDX_W-1:0] i);
        return DAC_BITS'(TGT_BASE + int'(i) * TGT_STEP);
    endfunction

    // sar_d is the current code with the bit under test resolved by the comparator
    always_comb begin
        q_sel    = bus.q[idx_q];
        slot_end = (cnt_q == SLOT_LAST);
        bit_mask = DAC_BITS'(1) << bit_q;
        sar_d    = q_sel ? (dac_q & ~bit_mask) : dac_q;
        idx_inc  = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            dac_q   <= '0;
            code_q  <= '0;
            trim_q  <= '0;
            sat_q   <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mv_q    <= 1'b0;
`ifdef CAL_VERIFY_EN
            verify_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            mv_q   <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    busy_q  <= 1'b1;
                    sat_q   <= '0;
                    idx_q   <= '0;
                    dac_q   <= '0;
                    state_q <= S_SAR_LOAD;
`ifdef CAL_VERIFY_EN
                    verify_q <= 1'b0;
`endif
                end
                S_SAR_LOAD: begin
                    dac_q   <= {1'b1, {(DAC_BITS-1){1'b0}}};
                    bit_q   <= BIT_W'(DAC_BITS - 1);
                    cnt_q   <= '0;
                    state_q <= S_SAR_SLOT;
                end
                S_SAR_SLOT: if (!slot_end) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                    if (bit_q == '0) begin
                        dac_q   <= sar_d;
                        code_q  <= sar_d;
                        mv_q    <= 1'b1;
                        state_q <= S_SAR_STORE;
                    end else begin
                        dac_q <= sar_d | (bit_mask >> 1);
                        bit_q <= bit_q - 1'b1;
                    end
                end
                S_SAR_STORE: if (idx_q != LAST) begin
                    idx_q   <= idx_inc;
                    dac_q   <= '0;
                    state_q <= S_SAR_LOAD;
`ifdef CAL_VERIFY_EN
                end else if (verify_q) begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
`endif
                end else begin
                    idx_q     <= '0;
                    dac_q     <= tgt_of('0);
                    trim_q[0] <= '0;
                    cnt_q     <= '0;
                    state_q   <= S_TRIM_ZERO;
                end
                // Zero-trim slot fixes the sign; magnitude then walks up from 1
                S_TRIM_ZERO: if (!slot_end) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q         <= '0;
                    sign_q        <= q_sel;
                    mag_q         <= MAG_W'(1);
                    trim_q[idx_q] <= {q_sel, MAG_W'(1)};
                    state_q       <= S_TRIM_STEP;
                end
                S_TRIM_STEP: if (!slot_end) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                    if (q_sel == sign_q && mag_q != MAG_MAX) begin
                        mag_q         <= mag_q + 1'b1;
                        trim_q[idx_q] <= {sign_q, mag_q + 1'b1};
                    end else begin
                        if (q_sel == sign_q) sat_q[idx_q] <= 1'b1;
                        if (idx_q != LAST) begin
                            idx_q           <= idx_inc;
                            dac_q           <= tgt_of(idx_inc);
                            trim_q[idx_inc] <= '0;
                            state_q         <= S_TRIM_ZERO;
                        end else begin
`ifdef CAL_VERIFY_EN
                            verify_q <= 1'b1;
                            idx_q    <= '0;
                            dac_q    <= '0;
                            state_q  <= S_SAR_LOAD;
`else
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
`endif
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.dac_ctl    = dac_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.meas_valid = mv_q;
    assign bus.meas_idx   = idx_q;
    assign bus.meas_code  = code_q;
    assign bus.trim_sat   = sat_q;

    // Upper comparators have inverted trim polarity in the analog bank
    for (genvar i = 0; i < N_CMP; i++) begin : g_cal
        if (i >= INV_FROM) begin : g_inv
            assign bus.cal[i*TRIM_BITS +: TRIM_BITS] = ~trim_q[i];
        end else begin : g_pass
            assign bus.cal[i*TRIM_BITS +: TRIM_BITS] = trim_q[i];
        end
    end
endmodule

// File: tb/tb_cmp_offset_calibrator.sv
// Bench for cmp_offset_calibrator: behavioural comparator bank, directed vector table, reset abort
// and randomized threshold runs checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cmp_offset_calibrator;
    localparam int NC = 4, DB = 8, TB = 5, SETTLE = 1;
    localparam int TGT_BASE = 16, TGT_STEP = 32, INV = 2;
    localparam int SPACING = DB * (SETTLE + 1) + 2;
    localparam int MAXC = (1 << DB) - 1;
    localparam int MAXM = (1 << (TB - 1)) - 1;
    localparam int WMASK = (1 << TB) - 1;

    typedef struct packed {
        logic [NC-1:0][15:0] thr;
        logic [NC-1:0][15:0] meas;
        logic [NC-1:0][4:0]  cal;
        logic [NC-1:0]       sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmp_offset_calibrator_if #(.N_CMP(NC), .DAC_BITS(DB), .TRIM_BITS(TB)) bus ();
    cmp_offset_calibrator #(
        .N_CMP(NC), .DAC_BITS(DB), .TRIM_BITS(TB), .SETTLE(SETTLE),
        .TGT_BASE(TGT_BASE), .TGT_STEP(TGT_STEP), .INV_FROM(INV)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    int thr [NC];
    logic [NC-1:0] q_w;
    int n_chk = 0, n_err = 0;
    int mv_code[$], mv_idx[$], mv_cyc[$];
    int done_n = 0, cyc = 0;

    // Comparator bank: trips when DAC code plus signed trim reaches the threshold
    function automatic int strim(input int i, input logic [NC*TB-1:0] c);
        logic [TB-1:0] w;
        w = c[i*TB +: TB];
        if (i >= INV) w = ~w;
        return w[TB-1] ? -int'(w[TB-2:0]) : int'(w[TB-2:0]);
    endfunction

    always_comb begin
        q_w = '0;
        for (int i = 0; i < NC; i++)
            q_w[i] = (int'(bus.dac_ctl) + strim(i, bus.cal)) >= thr[i];
    end
    assign bus.q = q_w;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!rst) begin
        if (bus.meas_valid) begin
            mv_code.push_back(int'(bus.meas_code));
            mv_idx.push_back(int'(bus.meas_idx));
            mv_cyc.push_back(cyc);
        end
        if (bus.done) done_n++;
    end

    function automatic int sar_ref(input int t, input int st);
        int r;
        r = t - st - 1;
        if (r < 0) r = 0;
        if (r > MAXC) r = MAXC;
        return r;
    endfunction

    function automatic int trim_ref(input int i, input int t, output bit sat);
        int tg, m;
        bit s;
        tg = (TGT_BASE + i * TGT_STEP) % (MAXC + 1);
        s = (tg >= t);
        m = s ? tg - t + 1 : t - tg;
        sat = (m > MAXM);
        if (sat) m = MAXM;
        return (s ? (1 << (TB - 1)) : 0) + m;
    endfunction

    function automatic int cal_of(input int i);
        logic [NC*TB-1:0] c;
        c = bus.cal;
        return int'(c[i*TB +: TB]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_cal(input bit poke);
        int w;
        mv_code.delete(); mv_idx.delete(); mv_cyc.delete();
        done_n = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(bus.busy), 1);
        chk("sat_clear_on_start", int'(bus.trim_sat), 0);
        if (poke) begin
            repeat (20) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        w = 0;
        while (!bus.done && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("done_within_budget", int'(w < 2000), 1);
        repeat (40) @(negedge clk);
        chk("busy_low_after_done", int'(bus.busy), 0);
        chk("done_pulses", done_n, 1);
    endtask

    task automatic check_run(input int em[NC], input int ec[NC], input int es);
        chk("meas_count", mv_code.size(), NC);
        for (int i = 0; i < NC && i < mv_code.size(); i++) begin
            chk($sformatf("meas_idx[%0d]", i), mv_idx[i], i);
            chk($sformatf("meas_code[%0d]", i), mv_code[i], em[i]);
            if (i > 0) chk($sformatf("meas_spacing[%0d]", i), mv_cyc[i] - mv_cyc[i-1], SPACING);
        end
        for (int i = 0; i < NC; i++) chk($sformatf("cal[%0d]", i), cal_of(i), ec[i]);
        chk("trim_sat", int'(bus.trim_sat), es);
    endtask

    initial begin
        vec_t vt [4];
        int em [NC];
        int ec [NC];
        int mt [NC];
        int mt_n [NC];
        int es, st;
        bit s;

        vt[0] = '{ {16'd130, 16'd90, 16'd50, 16'd10}, {16'd129, 16'd89, 16'd49, 16'd9},
                   {5'd16, 5'd21, 5'd2, 5'd23}, 4'b1000 };
        vt[1] = '{ {16'd112, 16'd80, 16'd48, 16'd16}, {16'd111, 16'd79, 16'd47, 16'd15},
                   {5'd14, 5'd14, 5'd17, 5'd17}, 4'b0000 };
        vt[2] = '{ {16'd112, 16'd80, 16'd48, 16'd40}, {16'd111, 16'd79, 16'd47, 16'd39},
                   {5'd14, 5'd14, 5'd17, 5'd15}, 4'b0001 };
        vt[3] = '{ {16'd300, 16'd256, 16'd255, 16'd0}, {16'd255, 16'd255, 16'd254, 16'd0},
                   {5'd16, 5'd16, 5'd15, 5'd31}, 4'b1111 };

        bus.start = 1'b0;
        for (int i = 0; i < NC; i++) thr[i] = 0;
        do_reset();
        @(negedge clk);
        chk("rst_dac", int'(bus.dac_ctl), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_meas_valid", int'(bus.meas_valid), 0);
        chk("rst_trim_sat", int'(bus.trim_sat), 0);
        for (int i = 0; i < NC; i++) chk($sformatf("rst_cal[%0d]", i), cal_of(i), (i >= INV) ? WMASK : 0);

        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < NC; i++) begin
                thr[i] = int'(vt[k].thr[i]);
                em[i]  = int'(vt[k].meas[i]);
                ec[i]  = int'(vt[k].cal[i]);
            end
            run_cal(1'b0);
            check_run(em, ec, int'(vt[k].sat));
        end

        // Reset during the trim search of comparator 0 aborts without done
        do_reset();
        thr[0] = 40; thr[1] = 48; thr[2] = 80; thr[3] = 112;
        done_n = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (80) @(posedge clk);
        #1 chk("mid_trim_dac", int'(bus.dac_ctl), TGT_BASE);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dac", int'(bus.dac_ctl), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        for (int i = 0; i < NC; i++) chk($sformatf("abort_cal[%0d]", i), cal_of(i), (i >= INV) ? WMASK : 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_done", done_n, 0);

        // Back-to-back random runs; trims from the previous run bias the next SAR
        do_reset();
        for (int i = 0; i < NC; i++) mt[i] = 0;
        for (int r = 0; r < 6; r++) begin
            es = 0;
            for (int i = 0; i < NC; i++) begin
                thr[i] = int'($urandom_range(0, 300));
                st = (mt[i] > MAXM) ? -(mt[i] - MAXM - 1) : mt[i];
                em[i] = sar_ref(thr[i], st);
                mt_n[i] = trim_ref(i, thr[i], s);
                if (s) es = es | (1 << i);
                ec[i] = (i >= INV) ? (~mt_n[i] & WMASK) : mt_n[i];
            end
            run_cal(r == 2);
            check_run(em, ec, es);
            for (int i = 0; i < NC; i++) mt[i] = mt_n[i];
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
